// File: rtl/encoder_layer_1_intermediate_dense_bias_sink_if.sv
// Bus bundle for the bias sink: the inbound beat stream and the read port.
// The sink is the slave; whoever loads and reads the biases is the master.
interface encoder_layer_1_intermediate_dense_bias_sink_if #(
   parameter int P      = 1,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 6
);
   logic [DATA_W-1:0] data_in [P];
   logic              data_in_valid;
   logic              data_in_ready;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data [P];
   logic              rd_valid;

   modport master (
      output data_in, data_in_valid, rd_en, rd_addr,
      input  data_in_ready, rd_data, rd_valid
   );

   modport slave (
      input  data_in, data_in_valid, rd_en, rd_addr,
      output data_in_ready, rd_data, rd_valid
   );
endinterface

// File: rtl/encoder_layer_1_intermediate_dense_bias_sink.sv
// Bias vector sink: loads one frame of beats into a RAM, then serves reads.
// Optional macro BIAS_SINK_CHECKSUM_EN enables a running sum of accepted elements.
module encoder_layer_1_intermediate_dense_bias_sink #(
   parameter int BIAS_TENSOR_SIZE_DIM_0 = 32,
   parameter int BIAS_TENSOR_SIZE_DIM_1 = 1,
   parameter int BIAS_PRECISION_0       = 16,
   parameter int BIAS_PRECISION_1       = 3,
   parameter int BIAS_PARALLELISM_DIM_0 = 1,
   parameter int BIAS_PARALLELISM_DIM_1 = 1,
   parameter int IN_DEPTH               = BIAS_TENSOR_SIZE_DIM_0 / BIAS_PARALLELISM_DIM_0
) (
   input  logic                                          clk,
   input  logic                                          rst,
   encoder_layer_1_intermediate_dense_bias_sink_if.slave bus,
   input  logic                                          clear,
   output logic                                          frame_done,
   output logic [31:0]                                   checksum
);

   localparam int P      = BIAS_PARALLELISM_DIM_0 * BIAS_PARALLELISM_DIM_1;
   localparam int W      = BIAS_PRECISION_0;
   localparam int WORD_W = P * W;
   localparam int IDX_W  = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
   localparam bit CFG_OK = (BIAS_TENSOR_SIZE_DIM_1 >= 1) && (BIAS_PRECISION_1 <= BIAS_PRECISION_0);

   // Fractional width and row count only describe the tensor; nothing here computes with them.
   if (!CFG_OK) begin : g_cfg_unused
   end

   typedef enum logic {LOAD = 1'b0, FULL = 1'b1} state_t;

   state_t              state, state_nxt;
   logic [IDX_W-1:0]    wr_ptr;
   logic                last_beat;
   logic                wr_en;
   logic [WORD_W-1:0]   wr_word;
   logic [WORD_W-1:0]   ram [IN_DEPTH];
   logic [IDX_W-1:0]    rd_idx;
   logic                rd_oob;
   logic [WORD_W-1:0]   rd_word_p0, rd_word_p1;
   logic                vld_p0, vld_p1;

   assign last_beat = (wr_ptr == IDX_W'(IN_DEPTH - 1));
   assign wr_en     = bus.data_in_valid && bus.data_in_ready && !rst;
   assign rd_idx    = bus.rd_addr[IDX_W-1:0];
   assign rd_oob    = (int'(bus.rd_addr) >= IN_DEPTH);

   always_comb begin
      wr_word = '0;
      for (int j = 0; j < P; j++) wr_word[j*W +: W] = bus.data_in[j];
   end

   always_ff @(posedge clk) begin
      if (rst) state <= LOAD;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         LOAD: if (clear) state_nxt = LOAD;
               else if (wr_en && last_beat) state_nxt = FULL;
         FULL: if (clear) state_nxt = LOAD;
         default: state_nxt = LOAD;
      endcase
   end

   always_comb begin
      bus.data_in_ready = (state == LOAD) && !clear;
      frame_done        = (state == FULL);
   end

   always_ff @(posedge clk) begin
      if (rst || clear)   wr_ptr <= '0;
      else if (wr_en)     wr_ptr <= last_beat ? '0 : wr_ptr + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (wr_en) ram[wr_ptr] <= wr_word;
   end

   // Read stage p0: RAM lookup; stage p1: output register held between reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p0 <= bus.rd_en;
         vld_p1 <= vld_p0;
      end
   end

   always_ff @(posedge clk) begin
      if (bus.rd_en) rd_word_p0 <= rd_oob ? '0 : ram[rd_idx];
      if (vld_p0)    rd_word_p1 <= rd_word_p0;
   end

   assign bus.rd_valid = vld_p1;

   always_comb begin
      for (int j = 0; j < P; j++) bus.rd_data[j] = rd_word_p1[j*W +: W];
   end

`ifdef BIAS_SINK_CHECKSUM_EN
   function automatic logic [31:0] beat_sum(input logic [WORD_W-1:0] word);
      logic [31:0] s;
      s = '0;
      for (int j = 0; j < P; j++) s = s + 32'(word[j*W +: W]);
      return s;
   endfunction

   logic [31:0] acc;

   always_ff @(posedge clk) begin
      if (rst || clear) acc <= '0;
      else if (wr_en)   acc <= acc + beat_sum(wr_word);
   end

   assign checksum = acc;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_encoder_layer_1_intermediate_dense_bias_sink.sv
// Randomized scoreboard bench for the bias sink (P=4, 32 elements, depth 8).
// Reads are predicted at issue time and checked by an independent monitor.
module tb_encoder_layer_1_intermediate_dense_bias_sink;
   localparam int P     = 4;
   localparam int W     = 16;
   localparam int DEPTH = 8;
   localparam int AW    = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic        frame_done;
   logic [31:0] checksum;

   encoder_layer_1_intermediate_dense_bias_sink_if #(.P(P), .DATA_W(W), .ADDR_W(AW)) ifc ();

   encoder_layer_1_intermediate_dense_bias_sink #(
      .BIAS_TENSOR_SIZE_DIM_0(32),
      .BIAS_TENSOR_SIZE_DIM_1(1),
      .BIAS_PRECISION_0(W),
      .BIAS_PRECISION_1(3),
      .BIAS_PARALLELISM_DIM_0(P),
      .BIAS_PARALLELISM_DIM_1(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc),
      .clear(clear),
      .frame_done(frame_done),
      .checksum(checksum)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef struct {
      logic [W-1:0] d [P];
      int           due;
      bit           chk;
   } rexp_t;
   rexp_t sbq [$];

   // Reference model: the frame is the list of beats accepted since the last clear/reset.
   logic [W-1:0] mram [DEPTH][P];
   bit           written [DEPTH];
   int           fill = 0;
   logic [31:0]  mcs  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
   endtask

   function automatic logic [31:0] exp_checksum();
`ifdef BIAS_SINK_CHECKSUM_EN
      return mcs;
`else
      return 32'd0;
`endif
   endfunction

   always @(negedge clk) begin
      if (ifc.rd_valid === 1'b1) begin
         if (sbq.size() == 0) begin
            check("rd_valid_unexpected", 32'd1, 32'd0);
         end else begin
            rexp_t e;
            e = sbq.pop_front();
            check("rd_latency", 32'(cyc), 32'(e.due));
            if (e.chk)
               for (int j = 0; j < P; j++)
                  check($sformatf("rd_data[%0d]", j), 32'(ifc.rd_data[j]), 32'(e.d[j]));
         end
      end
   end

   task automatic step();
      bit    acc;
      rexp_t e;
      if (ifc.rd_en && !rst) begin
         e.chk = (ifc.rd_addr < DEPTH) && written[ifc.rd_addr[2:0]];
         for (int j = 0; j < P; j++) e.d[j] = e.chk ? mram[ifc.rd_addr[2:0]][j] : '0;
         e.due = cyc + 2;
         sbq.push_back(e);
      end
      acc = ifc.data_in_valid && !rst && !clear && (fill < DEPTH);
      @(posedge clk);
      #1;
      if (rst || clear) begin
         fill = 0;
         mcs  = 0;
      end else if (acc) begin
         for (int j = 0; j < P; j++) begin
            mram[fill][j] = ifc.data_in[j];
            mcs = mcs + 32'(ifc.data_in[j]);
         end
         written[fill] = 1'b1;
         fill++;
      end
      check("frame_done", 32'(frame_done), 32'(fill == DEPTH));
      check("data_in_ready", 32'(ifc.data_in_ready), 32'((fill < DEPTH) && !clear));
      check("checksum", checksum, exp_checksum());
   endtask

   task automatic idle(input int n);
      ifc.data_in_valid = 1'b0;
      ifc.rd_en         = 1'b0;
      clear             = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      idle(3);
      rst = 1'b1;
      step();
      check("rst_rd_valid", 32'(ifc.rd_valid), 32'd0);
      rst = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   task automatic beat_fill(input logic [W-1:0] v);
      ifc.data_in_valid = 1'b1;
      for (int j = 0; j < P; j++) ifc.data_in[j] = v;
      step();
   endtask

   task automatic beat_rand();
      ifc.data_in_valid = 1'b1;
      for (int j = 0; j < P; j++) ifc.data_in[j] = W'($urandom);
      step();
   endtask

   task automatic read_all();
      ifc.data_in_valid = 1'b0;
      ifc.rd_en = 1'b1;
      for (int a = 0; a < DEPTH; a++) begin
         ifc.rd_addr = AW'(a);
         step();
      end
      idle(3);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      clear = 1'b0;
      ifc.data_in_valid = 1'b0;
      ifc.rd_en = 1'b0;
      ifc.rd_addr = '0;
      for (int j = 0; j < P; j++) ifc.data_in[j] = '0;
      step();
      step();
      check("rst_rd_valid", 32'(ifc.rd_valid), 32'd0);
      rst = 1'b0;

      // Continuous frame of 16*beat+j, then valid held while FULL.
      for (int b = 0; b < DEPTH; b++) begin
         ifc.data_in_valid = 1'b1;
         for (int j = 0; j < P; j++) ifc.data_in[j] = W'(16 * b + j);
         step();
      end
      for (int i = 0; i < 3; i++) beat_rand();
      ifc.data_in_valid = 1'b0;

      ifc.rd_en = 1'b1;
      ifc.rd_addr = AW'(3);
      step();
      read_all();

      // Valid toggling every cycle across a frame.
      pulse_clear();
      for (int c = 0; c < 2 * DEPTH; c++) begin
         ifc.data_in_valid = (c % 2 == 0);
         for (int j = 0; j < P; j++) ifc.data_in[j] = W'($urandom);
         step();
      end
      read_all();

      // Clear mid-load, clear coincident with valid, then an 0xAAAA frame.
      pulse_clear();
      for (int b = 0; b < 5; b++) beat_rand();
      clear = 1'b1;
      beat_rand();
      clear = 1'b0;
      for (int b = 0; b < DEPTH; b++) beat_fill(16'hAAAA);
      read_all();

      // Reset mid-frame, full reload, then reset while FULL.
      do_reset();
      for (int b = 0; b < 3; b++) beat_rand();
      do_reset();
      for (int b = 0; b < DEPTH; b++) beat_rand();
      read_all();
      do_reset();

      // All-ones frame for the checksum boundary.
      pulse_clear();
      for (int b = 0; b < DEPTH; b++) beat_fill(16'hFFFF);
      ifc.data_in_valid = 1'b0;
`ifdef BIAS_SINK_CHECKSUM_EN
      check("checksum_all_ones", checksum, 32'h001F_FFE0);
`else
      check("checksum_all_ones", checksum, 32'h0000_0000);
`endif
      read_all();

      // Out-of-range addresses: only rd_valid timing is defined.
      ifc.rd_en = 1'b1;
      for (int a = DEPTH; a < 2 * DEPTH; a++) begin
         ifc.rd_addr = AW'(a);
         step();
      end
      idle(3);

      // Random mix of loads, clears and overlapping reads.
      for (int i = 0; i < 400; i++) begin
         ifc.data_in_valid = 1'($urandom);
         clear             = ($urandom_range(0, 15) == 0);
         ifc.rd_en         = 1'($urandom);
         ifc.rd_addr       = AW'($urandom_range(0, DEPTH - 1));
         for (int j = 0; j < P; j++) ifc.data_in[j] = W'($urandom);
         step();
      end
      idle(4);

      for (int i = 0; i < 10 && sbq.size() > 0; i++) idle(1);
      check("reads_outstanding", 32'(sbq.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/encoder_layer_1_intermediate_dense_bias_sink.md
ENCODER_LAYER_1_INTERMEDIATE_DENSE_BIAS_SINK -- requirements
Module: encoder_layer_1_intermediate_dense_bias_sink

Interface
REQ-001 SHALL have parameter BIAS_TENSOR_SIZE_DIM_0, default 32, elements per bias vector.
REQ-002 SHALL have parameter BIAS_TENSOR_SIZE_DIM_1, default 1, rows per bias tensor.
REQ-003 SHALL have parameter BIAS_PRECISION_0, default 16, element width in bits.
REQ-004 SHALL have parameter BIAS_PRECISION_1, default 3, fractional bits; informational only, no arithmetic use.
REQ-005 SHALL have parameters BIAS_PARALLELISM_DIM_0 and BIAS_PARALLELISM_DIM_1, default 1 each, elements per beat = P = product.
REQ-006 SHALL have parameter IN_DEPTH, default BIAS_TENSOR_SIZE_DIM_0 / BIAS_PARALLELISM_DIM_0, beats per frame.
REQ-007 SHALL have port clk  input  1  sole clock, rising edge.
REQ-008 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-009 SHALL have port data_in  input  P x BIAS_PRECISION_0 unpacked array  incoming beat, element j at index j.
REQ-010 SHALL have port data_in_valid  input  1  beat present.
REQ-011 SHALL have port data_in_ready  output  1  sink can accept.
REQ-012 SHALL have port clear  input  1  single-cycle pulse, restart frame load.
REQ-013 SHALL have port frame_done  output  1  full frame stored.
REQ-014 SHALL have port rd_en  input  1  read request.
REQ-015 SHALL have port rd_addr  input  $clog2(IN_DEPTH)+1  beat index to read.
REQ-016 SHALL have port rd_data  output  P x BIAS_PRECISION_0 unpacked array  read beat.
REQ-017 SHALL have port rd_valid  output  1  rd_data valid.
REQ-018 SHALL have port checksum  output  32  frame checksum (see Configuration).

Function
REQ-019 SHALL store beats in internal RAM of IN_DEPTH entries, P*BIAS_PRECISION_0 bits each.
REQ-020 SHALL implement two states: LOAD and FULL.
REQ-021 SHALL drive data_in_ready = (state==LOAD) && !clear, combinationally.
REQ-022 SHALL, on data_in_valid && data_in_ready, write data_in to RAM[wr_ptr] and increment wr_ptr.
REQ-023 SHALL, on handshake with wr_ptr==IN_DEPTH-1, wrap wr_ptr to 0 and enter FULL next cycle.
REQ-024 SHALL assert frame_done exactly when state==FULL (registered, first high the cycle after the last beat).
REQ-025 SHALL, in FULL, ignore data_in_valid and retain RAM contents indefinitely.
REQ-026 SHALL, on clear in any state, set wr_ptr=0, state=LOAD, frame_done=0 next cycle; no beat accepted in the clear cycle.
REQ-027 SHALL, on clear mid-LOAD, discard the partial frame position (RAM not erased, overwritten on reload).
REQ-028 SHALL, on rd_en, return RAM[rd_addr] on rd_data with rd_valid high exactly 2 cycles later (two register stages).
REQ-029 SHALL serve reads in any state; same-cycle read and write to one address returns the old data.
REQ-030 SHALL hold rd_data when rd_valid low; rd_addr >= IN_DEPTH returns undefined data with rd_valid still asserted.
REQ-031 SHALL support back-to-back rd_en every cycle at full throughput.

Reset
REQ-032 SHALL, on rst high at a rising edge, set state=LOAD, wr_ptr=0, frame_done=0, rd_valid=0, checksum=0, read pipeline cleared; RAM contents not reset.
REQ-033 SHALL give rst priority over clear, handshakes and reads.

Configuration
REQ-034 SHALL, with macro BIAS_SINK_CHECKSUM_EN defined, accumulate checksum += zero-extended element values of every accepted beat, modulo 2^32, cleared by rst and clear.
REQ-035 SHALL, without BIAS_SINK_CHECKSUM_EN, keep the checksum port and drive it constant 0 with no accumulator logic.

Verification (P=4, BIAS_TENSOR_SIZE_DIM_0=32, IN_DEPTH=8)
REQ-036 Reset then 8 continuous beats, element value 16*beat+j -> frame_done high on cycle after beat 7, data_in_ready low thereafter.
REQ-037 Valid toggled 1/0 every cycle across a frame -> exactly 8 writes, frame_done after 16 cycles, RAM order beats 0..7.
REQ-038 In FULL, rd_en with addr 3 -> rd_data = {51,50,49,48} (element j at index j), rd_valid exactly 2 cycles later; 8 back-to-back reads return beats 0..7.
REQ-039 clear after 5 beats then 8 new beats of 0xAAAA -> all 8 entries read 0xAAAA; clear coincident with valid -> beat not accepted.
REQ-040 rst asserted mid-frame after 3 beats -> frame_done 0, next 8 beats form a complete frame; rst in FULL -> data_in_ready 1 next cycle.
REQ-041 With BIAS_SINK_CHECKSUM_EN, frame of all elements 0xFFFF -> checksum 0x1FFFE0 (32*0xFFFF); without macro -> checksum 0.
